// File: rtl/oram_bucket_pkg.sv
// Shared ORAM bucket header layout (offsets, widths, valid-field padding) for the read and writeback paths.
package oram_bucket_pkg;

    localparam int unsigned VALID_PAD_W = 32;

    typedef enum logic {
        ST_HEADER  = 1'b0,
        ST_PAYLOAD = 1'b1
    } reader_state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned valid_field_w(input int unsigned z);
        return ((z + VALID_PAD_W - 1) / VALID_PAD_W) * VALID_PAD_W;
    endfunction

    function automatic int unsigned valid_off(input int unsigned iv_w);
        return iv_w;
    endfunction

    function automatic int unsigned paddr_off(input int unsigned iv_w, input int unsigned z);
        return iv_w + valid_field_w(z);
    endfunction

    function automatic int unsigned leaf_off(input int unsigned iv_w, input int unsigned z,
                                             input int unsigned u);
        return paddr_off(iv_w, z) + z * u;
    endfunction

    function automatic int unsigned mac_off(input int unsigned iv_w, input int unsigned z,
                                            input int unsigned u, input int unsigned l);
        return leaf_off(iv_w, z, u) + z * l;
    endfunction

    function automatic int unsigned hdr_w(input int unsigned iv_w, input int unsigned z,
                                          input int unsigned u, input int unsigned l,
                                          input int unsigned h);
        return mac_off(iv_w, z, u, l) + z * h;
    endfunction

endpackage

// File: rtl/bucket_header_deser.sv
// Assembles a multi-chunk bucket header LSB-first; keeps only the low KeepW bits.
module bucket_header_deser
    import oram_bucket_pkg::*;
#(
    parameter int unsigned ChunkW  = 512,
    parameter int unsigned NChunks = 2,
    parameter int unsigned KeepW   = 864
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [ChunkW-1:0] in_data,
    output logic [KeepW-1:0]  hdr_q,
    output logic              done_c
);

    localparam int unsigned TotW = ChunkW * NChunks;
    localparam int unsigned CntW = cnt_w(NChunks);

    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cnt_d;
    logic [KeepW-1:0] hdr_d;
    logic [TotW-1:0]  frame;
    logic             beat;

    // Chunk c lands at bit c*ChunkW; bits above KeepW are never stored.
    always_comb begin
        beat   = en & in_valid;
        cnt_d  = cnt_q;
        hdr_d  = hdr_q;
        done_c = 1'b0;
        frame  = TotW'(hdr_q);
        if (beat) begin
            for (int unsigned c = 0; c < NChunks; c++) begin
                if (cnt_q == CntW'(c)) begin
                    frame[c*ChunkW +: ChunkW] = in_data;
                end
            end
            hdr_d = frame[KeepW-1:0];
            if (cnt_q == CntW'(NChunks - 1)) begin
                cnt_d  = '0;
                done_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            hdr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            hdr_q <= hdr_d;
        end
    end

endmodule

// File: rtl/dram_bucket_reader.sv
// Splits a DRAM bucket stream into header tags and a pass-through payload stream to the stash.
// Define DRAM_READER_MAC_EN to store the per-block MAC and drive it on StashMAC.
module dram_bucket_reader
    import oram_bucket_pkg::*;
#(
    parameter int unsigned     BEDWidth          = 512,
    parameter int unsigned     ORAMZ             = 4,
    parameter int unsigned     ORAMU             = 32,
    parameter int unsigned     ORAML             = 32,
    parameter int unsigned     ORAMH             = 128,
    parameter int unsigned     IVWidth           = 64,
    parameter int unsigned     HdrChunks         = 2,
    parameter int unsigned     BlkChunks         = 2,
    parameter logic [ORAMU-1:0] DummyBlockAddress = '1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [BEDWidth-1:0] DRAMData,
    input  logic                DRAMValid,
    output logic                DRAMReady,
    output logic [BEDWidth-1:0] StashData,
    output logic                StashValid,
    input  logic                StashReady,
    output logic [ORAMU-1:0]    StashPAddr,
    output logic [ORAML-1:0]    StashLeaf,
    output logic [ORAMH-1:0]    StashMAC,
    output logic                StashBlockLast,
    output logic                BucketDone
);

    localparam int unsigned ValidOff  = valid_off(IVWidth);
    localparam int unsigned PAddrOff  = paddr_off(IVWidth, ORAMZ);
    localparam int unsigned LeafOff   = leaf_off(IVWidth, ORAMZ, ORAMU);
    localparam int unsigned MacOff    = mac_off(IVWidth, ORAMZ, ORAMU, ORAML);
    localparam int unsigned HdrW      = hdr_w(IVWidth, ORAMZ, ORAMU, ORAML, ORAMH);
    localparam int unsigned TotW      = HdrChunks * BEDWidth;
`ifdef DRAM_READER_MAC_EN
    localparam int unsigned NeedW     = HdrW;
`else
    localparam int unsigned NeedW     = MacOff;
`endif
    localparam int unsigned KeepW     = (NeedW < TotW) ? NeedW : TotW;
    localparam int unsigned ChunkCntW = cnt_w(BlkChunks);
    localparam int unsigned BlkCntW   = cnt_w(ORAMZ);

    if (TotW < HdrW) begin : g_hdr_too_small
        $error("dram_bucket_reader: header chunks hold %0d bits, layout needs %0d", TotW, HdrW);
    end

    reader_state_e        state_q, state_d;
    logic [ChunkCntW-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [BlkCntW-1:0]   blk_cnt_q, blk_cnt_d;
    logic                 bucket_done_q, bucket_done_d;
    logic                 xfer;
    logic                 hdr_done_c;
    logic [KeepW-1:0]     hdr_q;
    logic                 valid_slot;
    logic [ORAMU-1:0]     paddr_slot;
    logic [ORAMH-1:0]     mac_slot;
    logic                 unused_hdr_bits;

    bucket_header_deser #(
        .ChunkW  (BEDWidth),
        .NChunks (HdrChunks),
        .KeepW   (KeepW)
    ) u_hdr (
        .clk      (Clock),
        .rst      (Reset),
        .en       (state_q == ST_HEADER),
        .in_valid (DRAMValid),
        .in_data  (DRAMData),
        .hdr_q    (hdr_q),
        .done_c   (hdr_done_c)
    );

    // IV and valid-field padding are carried in the header register but not consumed here.
    assign unused_hdr_bits = ^hdr_q;

    always_comb begin
        state_d       = state_q;
        chunk_cnt_d   = chunk_cnt_q;
        blk_cnt_d     = blk_cnt_q;
        bucket_done_d = 1'b0;
        DRAMReady     = 1'b1;
        StashValid    = 1'b0;
        xfer          = 1'b0;
        case (state_q)
            ST_HEADER: begin
                if (hdr_done_c) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                DRAMReady  = StashReady;
                StashValid = DRAMValid;
                xfer       = DRAMValid & StashReady;
                if (xfer) begin
                    if (chunk_cnt_q == ChunkCntW'(BlkChunks - 1)) begin
                        chunk_cnt_d = '0;
                        if (blk_cnt_q == BlkCntW'(ORAMZ - 1)) begin
                            blk_cnt_d     = '0;
                            state_d       = ST_HEADER;
                            bucket_done_d = 1'b1;
                        end else begin
                            blk_cnt_d = blk_cnt_q + BlkCntW'(1);
                        end
                    end else begin
                        chunk_cnt_d = chunk_cnt_q + ChunkCntW'(1);
                    end
                end
            end
        endcase
    end

    // Per-slot tag select; tags follow the block counter so they hold for a whole block.
    always_comb begin
        valid_slot = 1'b0;
        paddr_slot = '0;
        mac_slot   = '0;
        StashLeaf  = '0;
        for (int unsigned i = 0; i < ORAMZ; i++) begin
            if (blk_cnt_q == BlkCntW'(i)) begin
                valid_slot = hdr_q[ValidOff + i];
                paddr_slot = hdr_q[PAddrOff + i*ORAMU +: ORAMU];
                StashLeaf  = hdr_q[LeafOff + i*ORAML +: ORAML];
`ifdef DRAM_READER_MAC_EN
                mac_slot   = hdr_q[MacOff + i*ORAMH +: ORAMH];
`endif
            end
        end
    end

    assign StashPAddr     = valid_slot ? paddr_slot : DummyBlockAddress;
    assign StashMAC       = mac_slot;
    assign StashData      = DRAMData;
    assign StashBlockLast = StashValid & (chunk_cnt_q == ChunkCntW'(BlkChunks - 1));
    assign BucketDone     = bucket_done_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_HEADER;
            chunk_cnt_q   <= '0;
            blk_cnt_q     <= '0;
            bucket_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            chunk_cnt_q   <= chunk_cnt_d;
            blk_cnt_q     <= blk_cnt_d;
            bucket_done_q <= bucket_done_d;
        end
    end

endmodule
